// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: 16x oversampling, two-flop input synchroniser and a
// one-byte holding register with an empty/unload handshake.
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [DATA_W-1:0]   shift_reg, shift_n;
    logic [DATA_W-1:0]   data_n;
    logic                empty_n, busy_n, ferr_n, ovr_n;
    logic                load_c, bad_c;
    logic                rx_s1, rx_s;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick_c;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s  <= rx_s1;
        end
    end

    // Free-running oversample tick divider
    assign tick_c = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // State and holding register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_empty     <= 1'b1;
            rx_busy      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            shift_reg    <= shift_n;
            rx_data      <= data_n;
            rx_empty     <= empty_n;
            rx_busy      <= busy_n;
            rx_frame_err <= ferr_n;
            rx_overrun   <= ovr_n;
        end
    end

    // Next-state, sampling and handshake logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift_reg;
        data_n  = rx_data;
        empty_n = rx_empty;
        ferr_n  = rx_frame_err;
        ovr_n   = rx_overrun;
        load_c  = 1'b0;
        bad_c   = 1'b0;

        if (!rx_enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (tick_c) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    // This tick brings the count to 7: middle of the start bit
                    if (cnt == CNT_W'(6)) begin
                        cnt_n = '0;
                        idx_n = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(15)) begin
                        shift_n[idx] = rx_s;
                        cnt_n        = '0;
                        idx_n        = idx + IDX_W'(1);
                        if (idx == IDX_W'(7)) begin
                            state_n = STOP;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_W'(15)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        load_c  = rx_s;
                        bad_c   = !rx_s;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (uld_rx_data) begin
            empty_n = 1'b1;
            ferr_n  = 1'b0;
            ovr_n   = 1'b0;
        end

        // A load in the same cycle as an unload wins over the unload
        if (load_c) begin
            data_n  = shift_reg;
            empty_n = 1'b0;
            if (!rx_empty && !uld_rx_data) begin
                ovr_n = 1'b1;
            end
        end

        if (bad_c) begin
            ferr_n = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

endmodule
